// File: rtl/mips_fetch_pkg.sv
// Shared state encoding and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction fetched while IF/ID was stalled.
module fetch_skid_buf
    import mips_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] instr_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_o
);

    logic             valid_q;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] pc_q;

    // Buffer storage; a clear wins over a simultaneous load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= WIDTH'(NOP_INSTR);
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the one-outstanding imem handshake,
// and feeds IF/ID with either a real instruction or a NOP bubble.
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_pc_plus4
);

    localparam logic [WIDTH-1:0] INCR = WIDTH'(PC_INCR);
    localparam logic [WIDTH-1:0] NOP  = WIDTH'(NOP_INSTR);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] stale_q, stale_d;
    logic             active_q;
    logic             buf_load_s, buf_clear_s, buf_valid_s;
    logic [WIDTH-1:0] buf_instr_s, buf_pc_s;

    fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (buf_load_s),
        .clear_i (buf_clear_s),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (buf_valid_s),
        .instr_o (buf_instr_s),
        .pc_o    (buf_pc_s)
    );

    // Next-state, PC update and IF/ID-facing outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stale_d     = stale_q;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = pc_q;
        if_valid    = 1'b0;
        if_instr    = NOP;
        if_pc       = pc_q;
        case (state_q)
            ST_FETCH: begin
                // active_q keeps the request low until the first edge out of reset
                imem_req = active_q;
                if (redirect) begin
                    pc_d        = redirect_pc;
                    buf_clear_s = 1'b1;
                    if (active_q && !imem_ack) begin
                        stale_d = pc_q;
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (active_q && imem_ack) begin
                    if_valid = 1'b1;
                    if_instr = imem_rdata;
                    pc_d     = pc_q + INCR;
                    if (stall) begin
                        buf_load_s = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if_pc = buf_pc_s;
                if (redirect) begin
                    pc_d        = redirect_pc;
                    buf_clear_s = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    if_valid = buf_valid_s;
                    if_instr = buf_valid_s ? buf_instr_s : NOP;
                    if (!stall) begin
                        buf_clear_s = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = stale_q;
                if (redirect) begin
                    pc_d        = redirect_pc;
                    buf_clear_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
                state_d = imem_ack ? ST_FETCH : ST_DISCARD;
            end
            default: begin
                buf_clear_s = 1'b1;
                state_d     = ST_FETCH;
            end
        endcase
        if_pc_plus4 = if_pc + INCR;
    end

    // State, PC and stale-address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            stale_q  <= RESET_PC;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            stale_q  <= stale_d;
            active_q <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the IF/ID pipeline register. Owns the PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and presents the fetched instruction with its PC and PC+4. It honours the hazard unit's stall, and on a branch/jump redirect it drops any in-flight or buffered instruction. When no instruction is valid it presents a NOP bubble, so the IF/ID register can load unconditionally whenever it is not stalled.

## Interface
- WIDTH, 32, address and instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit holds IF/ID; the presented instruction is not consumed this cycle
- redirect  in  1  taken branch/jump; flush fetch
- redirect_pc  in  WIDTH  target address, valid when redirect=1
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  request address; held stable while imem_req=1 and no ack
- imem_ack  in  1  single-cycle response strobe; may assert in the same cycle as imem_req
- imem_rdata  in  WIDTH  instruction, valid only when imem_ack=1
- if_valid  out  1  if_instr/if_pc are a real instruction
- if_instr  out  WIDTH  instruction to IF/ID; 32'h0000_0000 (NOP) when if_valid=0
- if_pc  out  WIDTH  PC of if_instr
- if_pc_plus4  out  WIDTH  if_pc+4, modulo 2^WIDTH

## Operation
- States: FETCH (request outstanding), HOLD (instruction buffered, waiting for stall release), DISCARD (stale request outstanding; its response is dropped).
- imem_req = 1 in FETCH and DISCARD, 0 in HOLD. imem_addr = pc in FETCH, = the stale address in DISCARD.
- FETCH, ack, stall=0, no redirect: if_valid=1 with if_instr=imem_rdata (combinational pass-through); pc<=pc+4; stay in FETCH.
- FETCH, ack, stall=1, no redirect: capture rdata and pc into the skid buffer; pc<=pc+4; go to HOLD.
- FETCH, no ack: if_valid=0 (bubble).
- HOLD: if_valid=1 from the buffer. Go to FETCH when stall=0.
- Redirect has the highest priority and overrides stall. In every state:
  - pc<=redirect_pc.
  - Buffer is invalidated.
  - if_valid is forced 0 that cycle.
  - Next state:
    - FETCH without ack → DISCARD (old address held until its ack).
    - FETCH with ack → FETCH (data dropped).
    - HOLD → FETCH.
    - DISCARD → stays DISCARD (pc updated again).
- DISCARD: if_valid=0. On ack, drop the data and go to FETCH.
- PC arithmetic: unsigned, wraps 32'hFFFF_FFFC → 32'h0000_0000. No alignment checking; the low 2 bits pass through as given.

## Timing
- Reset (reset=0, asynchronous): state=FETCH, pc=RESET_PC, buffer invalid, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4.
- First imem_req=1 in the first cycle after reset deasserts.
- Zero-wait memory (ack in the request cycle): one instruction per cycle; 0-cycle latency from ack to if_valid.
- N-wait memory: N bubble cycles per instruction.
- Redirect with no request outstanding, or with ack in the redirect cycle: imem_addr=redirect_pc in the next cycle.
- Redirect with an outstanding unacked request: new address issued in the cycle after the stale ack.
- Stall release from HOLD: buffered instruction presented until the release edge; next request begins the following cycle.
- reset asserted mid-request or mid-DISCARD: all state cleared immediately. The memory side must also be reset, so no stale ack is expected.

## Structure
- Shared package mips_fetch_pkg: state encoding (FETCH, HOLD, DISCARD), NOP_INSTR = 32'h0, PC_INCR = 4.
- One sub-module: fetch_skid_buf, a one-entry buffer with instr, pc and valid fields; load, clear and async active-low reset.
- The PC register and FSM live in fetch_stage.

## Test plan
- Zero-wait memory, stall=0, RESET_PC=0 → imem_addr 0,4,8,C on consecutive cycles; if_valid=1 each cycle; if_pc_plus4 = if_pc+4.
- 2-wait memory → exactly 2 bubble cycles (if_valid=0, if_instr=0) before each instruction.
- Ack at addr 0x10 with stall=1 for 3 cycles → HOLD:
  - imem_req=0 during the stall.
  - if_pc=0x10 stable.
  - After release, next imem_addr=0x14.
- Redirect to 0x400 while a request to 0x20 is waiting, ack 2 cycles later:
  - imem_addr stays 0x20 until the ack.
  - The 0x20 data is never presented with if_valid=1.
  - Next imem_addr=0x400.
- Redirect and stall in the same cycle in HOLD → buffer dropped, if_valid=0, next imem_addr=redirect_pc.
- PC at 0xFFFF_FFFC acked → next imem_addr=0; reset pulsed mid-wait → all outputs return to their reset values immediately.
